axi_read_arbiter: RTL
=====================

# axi_read_arbiter

Parametrised AXI3 read-channel master that arbitrates instruction-fetch and data-load requests from the openmips core onto a single AR/R channel pair. It supports both single-beat and fixed-length INCR burst reads for cache-line fills. It is the successor to the single-beat read adapter in the AXI wrapper, and sits between the core (or its caches) and the AXI interconnect. Exactly one transaction is outstanding at a time.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; legal values 32 or 64
- BURST_LEN, 4, beats per burst request; range 2..16
- INST_ID, 4'd0, arid used for instruction requests
- DATA_ID, 4'd1, arid used for data requests

Ports:
- clk  in  1  clock; the only clock
- reset  in  1  synchronous, active-high
- inst_req_valid / data_req_valid  in  1  per-port request
- inst_req_addr / data_req_addr  in  ADDR_W  byte address
- inst_req_burst / data_req_burst  in  1  1 = BURST_LEN-beat burst, 0 = single beat
- inst_req_ready / data_req_ready  out  1  one-cycle accept pulse
- inst_rdata / data_rdata  out  DATA_W  returned beat
- inst_rvalid / data_rvalid  out  1  beat strobe; no backpressure, the port must sink it
- inst_rlast / data_rlast  out  1  final beat of the transaction
- inst_rerr / data_rerr  out  1  error qualifier on the rlast beat
- arid 4, araddr ADDR_W, arlen 4, arsize 3, arburst 2, arlock 2, arcache 4, arprot 3, arvalid 1  out  AXI3 read address channel
- arready  in  1
- rid 4, rdata DATA_W, rresp 2, rlast 1, rvalid 1  in  AXI3 read data channel
- rready  out  1

## Operation
- States:
  - IDLE: evaluate requests.
  - ADDR: arvalid held.
  - DATA: collecting beats.
- IDLE to ADDR:
  - If any req_valid is high, grant one port and pulse its req_ready.
  - Latch the address, burst flag and ID.
- Address formation:
  - Burst: address aligned down to BURST_LEN*DATA_W/8 bytes; arlen = BURST_LEN-1.
  - Single: address unchanged; arlen = 0.
- Fixed AXI fields: arsize = log2(DATA_W/8), arburst = 2'b01 (INCR), arlock = 0, arcache = 0, arprot = 0.
- ADDR to DATA on arvalid && arready.
- arvalid and all ar* fields stay stable until the handshake completes.
- DATA state:
  - rready = 1.
  - A beat counter increments on each rvalid beat.
  - Each beat is registered and forwarded to the granted port.
- Error detection (err is sticky within the transaction, reported with the last forwarded beat):
  - rresp != 0 on any beat.
  - rid != latched ID.
  - rlast arrives before the expected count.
  - Expected count reached without rlast.
- Transaction end:
  - rlast, or the expected count reached, returns the FSM to IDLE.
  - The forwarded rlast is forced on that final beat.
- The port's req_addr and req_burst are sampled only in the cycle its req_ready pulses.

## Timing
- Reset values: all outputs 0. This covers arvalid, rready, req_ready, rvalid, rlast, rerr, araddr, arid, arlen and rdata.
- reset mid-transaction: FSM to IDLE in the same edge, counter cleared, pending beats dropped. Reset is system-wide, so the slave resets too.
- Request latency:
  - req_valid seen in IDLE at cycle N gives req_ready at N (combinational from FSM state and arbitration).
  - arvalid is high from N+1.
- Return latency: AXI beat accepted at cycle M appears on the port rvalid at M+1.
- Minimum single-read turnaround: accept N, AR handshake N+1, R beat N+2, port beat N+3, IDLE at N+3 ready for a new grant.
- Back-to-back beats stream at one per cycle with no bubbles.
- Only one port's rvalid is high in any cycle.

## Configuration
- AXI_RD_ROUND_ROBIN_EN defined:
  - Round-robin arbitration; a one-bit last-grant register favours the port not granted last.
  - Reset value favours data.
- AXI_RD_ROUND_ROBIN_EN undefined:
  - Fixed priority, data over instruction.
  - Instruction starvation is permitted.

## Structure
- Shared package/defines file holds:
  - FSM state encodings (AR_IDLE, AR_ADDR, AR_DATA).
  - AXI constants: AXI_BURST_INCR = 2'b01, AXI_RESP_OKAY = 2'b00.
  - Port select encoding.
- One natural sub-module, axi_rd_arbiter_grant: two-input arbiter producing the grant one-hot, with the round-robin state under the macro.

## Test plan
- Single inst read, addr 0xBFC00004, slave returns 0x24080001 with rresp 0, rid 0:
  - arlen = 0, araddr = 0xBFC00004.
  - inst_rvalid, inst_rlast, inst_rdata = 0x24080001, rerr = 0.
- Data burst, addr 0x8000_0014, BURST_LEN 4:
  - araddr = 0x8000_0010, arlen = 3, arid = 1.
  - Four data_rvalid beats on consecutive cycles; rlast only on the 4th.
- Both ports request in the same cycle three times in a row:
  - Fixed priority: data, data, data.
  - With AXI_RD_ROUND_ROBIN_EN: data, inst, data.
- arready held low for 5 cycles: arvalid and araddr stay constant throughout; exactly one AR handshake.
- Burst where beat 2 carries rresp = 2'b10, and a separate burst where rlast arrives on beat 3:
  - rerr = 1 on the final forwarded beat.
  - FSM returns to IDLE.
- reset asserted during beat 2 of a burst: next cycle all outputs are 0, state is IDLE, and a new request is granted normally.

Source files
------------

// File: rtl/axi_read_arbiter_pkg.sv
// Shared types and AXI constants for the openmips AXI3 read arbiter.
// Build option: AXI_RD_ROUND_ROBIN_EN selects round-robin arbitration (default is fixed priority).
package axi_read_arbiter_pkg;

    typedef enum logic [1:0] {
        AR_IDLE = 2'd0,
        AR_ADDR = 2'd1,
        AR_DATA = 2'd2
    } ar_state_e;

    typedef enum logic {
        PORT_INST = 1'b0,
        PORT_DATA = 1'b1
    } port_sel_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // arsize encoding for a full-width beat.
    function automatic logic [2:0] axi_size(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/axi_rd_arbiter_grant.sv
// Two-port request arbiter: fixed data-over-instruction priority, or round-robin
// with a one-bit last-grant register when AXI_RD_ROUND_ROBIN_EN is defined.
module axi_rd_arbiter_grant
    import axi_read_arbiter_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      inst_valid,
    input  logic      data_valid,
    input  logic      take,
    output port_sel_e grant_sel
);

`ifdef AXI_RD_ROUND_ROBIN_EN
    port_sel_e last_sel_q;

    // Resetting to "instruction granted last" makes data the first winner.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_sel_q <= PORT_INST;
        end else if (take) begin
            last_sel_q <= grant_sel;
        end
    end

    assign grant_sel = (data_valid && !(inst_valid && last_sel_q == PORT_DATA))
                       ? PORT_DATA : PORT_INST;
`else
    logic unused_rr;
    assign unused_rr = &{1'b0, clk, reset, take, inst_valid};

    assign grant_sel = data_valid ? PORT_DATA : PORT_INST;
`endif

endmodule

// File: rtl/axi_read_arbiter.sv
// AXI3 read master arbitrating instruction/data requests onto one AR/R pair,
// one transaction outstanding. Build option: AXI_RD_ROUND_ROBIN_EN (see grant sub-module).
module axi_read_arbiter
    import axi_read_arbiter_pkg::*;
#(
    parameter int         ADDR_W    = 32,
    parameter int         DATA_W    = 32,
    parameter int         BURST_LEN = 4,
    parameter logic [3:0] INST_ID   = 4'd0,
    parameter logic [3:0] DATA_ID   = 4'd1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_req_valid,
    input  logic [ADDR_W-1:0] inst_req_addr,
    input  logic              inst_req_burst,
    output logic              inst_req_ready,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_rvalid,
    output logic              inst_rlast,
    output logic              inst_rerr,
    input  logic              data_req_valid,
    input  logic [ADDR_W-1:0] data_req_addr,
    input  logic              data_req_burst,
    output logic              data_req_ready,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_rvalid,
    output logic              data_rlast,
    output logic              data_rerr,
    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [3:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic [1:0]        arlock,
    output logic [3:0]        arcache,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,
    input  logic [3:0]        rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready
);

    localparam logic [ADDR_W-1:0] LINE_BYTES  = ADDR_W'(BURST_LEN * DATA_W / 8);
    localparam logic [4:0]        BURST_BEATS = 5'(BURST_LEN);

    ar_state_e         state_q, state_d;
    port_sel_e         sel_q, grant_sel;
    logic [ADDR_W-1:0] addr_q, req_addr;
    logic              burst_q, req_burst;
    logic [3:0]        id_q;
    logic [4:0]        beat_cnt_q, beat_num;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q, rlast_q, rerr_q;
    logic              any_req, take, beat, last_expected, final_beat, beat_err;

    axi_rd_arbiter_grant u_grant (
        .clk        (clk),
        .reset      (reset),
        .inst_valid (inst_req_valid),
        .data_valid (data_req_valid),
        .take       (take),
        .grant_sel  (grant_sel)
    );

    assign any_req   = inst_req_valid | data_req_valid;
    assign take      = (state_q == AR_IDLE) && any_req;
    assign req_addr  = (grant_sel == PORT_DATA) ? data_req_addr  : inst_req_addr;
    assign req_burst = (grant_sel == PORT_DATA) ? data_req_burst : inst_req_burst;

    // Early rlast and a missing rlast are both a mismatch against the expected count.
    assign beat          = rvalid && rready;
    assign beat_num      = beat_cnt_q + 5'd1;
    assign last_expected = beat_num == (burst_q ? BURST_BEATS : 5'd1);
    assign final_beat    = rlast || last_expected;
    assign beat_err      = (rresp != AXI_RESP_OKAY) || (rid != id_q) || (rlast != last_expected);

    // NOTE: every output of a combinational block gets a default first, so no path leaves a latch.
    always_comb begin
        state_d        = state_q;
        arvalid        = 1'b0;
        rready         = 1'b0;
        inst_req_ready = 1'b0;
        data_req_ready = 1'b0;
        unique case (state_q)
            AR_IDLE: begin
                inst_req_ready = any_req && (grant_sel == PORT_INST);
                data_req_ready = any_req && (grant_sel == PORT_DATA);
                if (any_req) state_d = AR_ADDR;
            end
            AR_ADDR: begin
                arvalid = 1'b1;
                if (arready) state_d = AR_DATA;
            end
            AR_DATA: begin
                rready = 1'b1;
                if (rvalid && final_beat) state_d = AR_IDLE;
            end
            default: state_d = AR_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the data path registers are reset too, because every port output must read 0 out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= AR_IDLE;
            sel_q      <= PORT_INST;
            addr_q     <= '0;
            burst_q    <= 1'b0;
            id_q       <= 4'd0;
            beat_cnt_q <= 5'd0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rerr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rerr_q   <= 1'b0;
            if (take) begin
                sel_q      <= grant_sel;
                addr_q     <= req_burst ? req_addr - (req_addr % LINE_BYTES) : req_addr;
                burst_q    <= req_burst;
                id_q       <= (grant_sel == PORT_DATA) ? DATA_ID : INST_ID;
                beat_cnt_q <= 5'd0;
                err_q      <= 1'b0;
            end
            if (beat) begin
                beat_cnt_q <= beat_num;
                err_q      <= err_q | beat_err;
                rdata_q    <= rdata;
                rvalid_q   <= 1'b1;
                rlast_q    <= final_beat;
                rerr_q     <= final_beat & (err_q | beat_err);
            end
        end
    end

    assign araddr  = addr_q;
    assign arid    = id_q;
    assign arlen   = burst_q ? 4'(BURST_LEN - 1) : 4'd0;
    assign arsize  = arvalid ? axi_size(DATA_W) : 3'd0;
    assign arburst = arvalid ? AXI_BURST_INCR : 2'b00;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;

    assign inst_rdata  = rdata_q;
    assign data_rdata  = rdata_q;
    assign inst_rvalid = rvalid_q && (sel_q == PORT_INST);
    assign data_rvalid = rvalid_q && (sel_q == PORT_DATA);
    assign inst_rlast  = rlast_q  && (sel_q == PORT_INST);
    assign data_rlast  = rlast_q  && (sel_q == PORT_DATA);
    assign inst_rerr   = rerr_q   && (sel_q == PORT_INST);
    assign data_rerr   = rerr_q   && (sel_q == PORT_DATA);

endmodule
